// File: rtl/vx_commit_tracker_pkg.sv
// Shared constants for the commit tracker: machine geometry, default
// in-flight counter width, fence FSM encodings and the warp-to-slot mapping.
package vx_commit_tracker_pkg;

  localparam int ISSUE_WIDTH   = 4;
  localparam int NUM_WARPS     = 8;
  localparam int NW_WIDTH      = $clog2(NUM_WARPS);
  localparam int PENDING_CTR_W = 4;

  typedef logic [1:0] fence_state_t;

  localparam fence_state_t FENCE_IDLE = 2'd0;
  localparam fence_state_t FENCE_WAIT = 2'd1;
  localparam fence_state_t FENCE_DONE = 2'd2;

  // Warps are statically bound to issue slots, so a warp can only ever
  // appear on the slot selected here.
  function automatic int unsigned slot_of(input int unsigned wid);
    return wid % ISSUE_WIDTH;
  endfunction

endpackage

// File: rtl/vx_commit_tracker_if.sv
// Issue / commit / fence bundle between the scheduler side (master) and
// the commit tracker (slave).
interface vx_commit_tracker_if;
  import vx_commit_tracker_pkg::*;

  logic [ISSUE_WIDTH-1:0]               issue_valid;
  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0] issue_wid;
  logic [ISSUE_WIDTH-1:0]               issue_ready;

  logic [ISSUE_WIDTH-1:0]               committed;
  logic [ISSUE_WIDTH-1:0][NW_WIDTH-1:0] committed_wid;

  logic                                 fence_valid;
  logic [NW_WIDTH-1:0]                  fence_wid;
  logic                                 fence_ready;
  logic                                 fence_done;

  logic [NUM_WARPS-1:0]                 pending;
  logic                                 idle;

  modport master (
    output issue_valid, issue_wid, committed, committed_wid, fence_valid, fence_wid,
    input  issue_ready, fence_ready, fence_done, pending, idle
  );

  modport slave (
    input  issue_valid, issue_wid, committed, committed_wid, fence_valid, fence_wid,
    output issue_ready, fence_ready, fence_done, pending, idle
  );

endinterface

// File: rtl/vx_commit_tracker_pending_counter.sv
// Per-warp in-flight instruction counter: saturating up/down, never wraps.
// Simultaneous increment and decrement cancel out.
module vx_commit_tracker_pending_counter #(
  parameter int CTR_W   = 4,
  parameter int CORE_ID = 0,
  parameter int WARP_ID = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] count;

  // Count up on issue, down on commit, clamped at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != CTR_MAX)) begin
      count <= count + CTR_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

  assign full = (count == CTR_MAX);
  assign zero = (count == '0);

`ifndef SYNTHESIS
  // Flag a commit arriving for a warp that has nothing in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && !inc && zero))
        else $warning("core%0d warp%0d: commit with no instruction in flight", CORE_ID, WARP_ID);
    end
  end
`endif

endmodule

// File: rtl/vx_commit_tracker.sv
// Tracks in-flight instructions per warp, back-pressures issue when a
// warp's counter is full, and runs a per-warp drain fence.
module vx_commit_tracker
  import vx_commit_tracker_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int CTR_W   = PENDING_CTR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_commit_tracker_if.slave   bus
);

  logic [ISSUE_WIDTH-1:0] issue_ready_int;
  logic [ISSUE_WIDTH-1:0] issue_fire;
  logic [NUM_WARPS-1:0]   warp_inc;
  logic [NUM_WARPS-1:0]   warp_dec;
  logic [NUM_WARPS-1:0]   warp_full;
  logic [NUM_WARPS-1:0]   warp_zero;

  fence_state_t        state;
  fence_state_t        state_n;
  logic [NW_WIDTH-1:0] fence_wid_q;

  // A slot may issue unless its warp is full and no commit frees an entry
  // in the same cycle; a fire only counts outside reset.
  always_comb begin
    issue_ready_int = '0;
    issue_fire      = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      issue_ready_int[i] = reset
                        || !warp_full[bus.issue_wid[i]]
                        || (bus.committed[i] && (bus.committed_wid[i] == bus.issue_wid[i]));
      issue_fire[i]      = bus.issue_valid[i] && issue_ready_int[i] && !reset;
    end
  end

  assign bus.issue_ready = issue_ready_int;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    localparam int SLOT = slot_of(w);

    assign warp_inc[w] = issue_fire[SLOT] && (bus.issue_wid[SLOT] == NW_WIDTH'(w));
    assign warp_dec[w] = bus.committed[SLOT] && !reset
                      && (bus.committed_wid[SLOT] == NW_WIDTH'(w));

    vx_commit_tracker_pending_counter #(
      .CTR_W   (CTR_W),
      .CORE_ID (CORE_ID),
      .WARP_ID (w)
    ) u_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (warp_inc[w]),
      .dec   (warp_dec[w]),
      .full  (warp_full[w]),
      .zero  (warp_zero[w])
    );
  end

  assign bus.pending = ~warp_zero;
  assign bus.idle    = &warp_zero;

  // Fence sequencing: accept, wait for the warp to drain with no new issue
  // racing in, then pulse done for a single cycle.
  always_comb begin
    state_n = state;
    case (state)
      FENCE_IDLE: if (bus.fence_valid) state_n = FENCE_WAIT;
      FENCE_WAIT: if (warp_zero[fence_wid_q] && !warp_inc[fence_wid_q]) state_n = FENCE_DONE;
      FENCE_DONE: state_n = FENCE_IDLE;
      default:    state_n = FENCE_IDLE;
    endcase
  end

  // Fence state register and captured warp id.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FENCE_IDLE;
      fence_wid_q <= '0;
    end else begin
      state <= state_n;
      if ((state == FENCE_IDLE) && bus.fence_valid) begin
        fence_wid_q <= bus.fence_wid;
      end
    end
  end

  assign bus.fence_ready = (state == FENCE_IDLE);
  assign bus.fence_done  = (state == FENCE_DONE);

`ifdef DBG_TRACE_CORE_PIPELINE
  // Trace fence acceptance and completion.
  always_ff @(posedge clk) begin
    if (!reset && (state == FENCE_IDLE) && bus.fence_valid) begin
      $display("%t: core%0d-fence-accept: wid=%0d", $time, CORE_ID, bus.fence_wid);
    end
    if (!reset && (state == FENCE_DONE)) begin
      $display("%t: core%0d-fence-done: wid=%0d", $time, CORE_ID, fence_wid_q);
    end
  end
`endif

endmodule

// File: tb/tb_vx_commit_tracker.sv
// Directed bench for vx_commit_tracker built with a 2-bit counter so that
// saturation is reachable in a few issues.
module tb_vx_commit_tracker;
  import vx_commit_tracker_pkg::*;

  localparam int WB = ISSUE_WIDTH * NW_WIDTH;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  vx_commit_tracker_if bus ();

  vx_commit_tracker #(
    .CORE_ID (0),
    .CTR_W   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WB-1:0] slotWid(input int slot, input int wid);
    logic [WB-1:0] v;
    v = '0;
    v[slot*NW_WIDTH +: NW_WIDTH] = NW_WIDTH'(wid);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ISSUE_WIDTH-1:0] iv, input logic [WB-1:0] iw,
                               input logic [ISSUE_WIDTH-1:0] cm, input logic [WB-1:0] cw,
                               input logic fv, input logic [NW_WIDTH-1:0] fw);
    bus.issue_valid   = iv;
    bus.issue_wid     = iw;
    bus.committed     = cm;
    bus.committed_wid = cw;
    bus.fence_valid   = fv;
    bus.fence_wid     = fw;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_pending", 32'(bus.pending), 'h00);
    checkOutput("rst_idle", 32'(bus.idle), 'h1);
    checkOutput("rst_fence_ready", 32'(bus.fence_ready), 'h1);
    checkOutput("rst_fence_done", 32'(bus.fence_done), 'h0);
    checkOutput("rst_issue_ready", 32'(bus.issue_ready), 'hF);
    reset = 1'b0;

    // three issues to warp 2, then three commits
    applyStimulus(4'b0100, slotWid(2, 2), '0, '0, 1'b0, '0);
    tick(); tick(); tick();
    applyStimulus('0, slotWid(2, 2), '0, '0, 1'b0, '0);
    checkOutput("w2_pending", 32'(bus.pending), 'h04);
    checkOutput("w2_idle", 32'(bus.idle), 'h0);
    checkOutput("w2_full_ready", 32'(bus.issue_ready), 'hB);
    applyStimulus('0, slotWid(2, 2), 4'b0100, slotWid(2, 2), 1'b0, '0);
    checkOutput("w2_commit_ready", 32'(bus.issue_ready), 'hF);
    tick(); tick();
    checkOutput("w2_one_left", 32'(bus.pending), 'h04);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w2_drained_pending", 32'(bus.pending), 'h00);
    checkOutput("w2_drained_idle", 32'(bus.idle), 'h1);

    // saturate warp 1, then issue and commit together while full
    applyStimulus(4'b0010, slotWid(1, 1), '0, '0, 1'b0, '0);
    tick(); tick(); tick();
    applyStimulus('0, slotWid(1, 1), '0, '0, 1'b0, '0);
    checkOutput("w1_full_ready", 32'(bus.issue_ready), 'hD);
    applyStimulus(4'b0010, slotWid(1, 1), 4'b0010, slotWid(1, 1), 1'b0, '0);
    checkOutput("w1_full_commit_ready", 32'(bus.issue_ready), 'hF);
    tick();
    applyStimulus('0, slotWid(1, 1), '0, '0, 1'b0, '0);
    checkOutput("w1_stays_full", 32'(bus.issue_ready), 'hD);
    checkOutput("w1_pending", 32'(bus.pending), 'h02);
    applyStimulus('0, slotWid(1, 1), 4'b0010, slotWid(1, 1), 1'b0, '0);
    tick(); tick(); tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w1_drained", 32'(bus.pending), 'h00);

    // warp 0 at 1, simultaneous issue and commit keeps it at 1
    applyStimulus(4'b0001, slotWid(0, 0), '0, '0, 1'b0, '0);
    tick();
    applyStimulus(4'b0001, slotWid(0, 0), 4'b0001, slotWid(0, 0), 1'b0, '0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w0_same_cycle", 32'(bus.pending), 'h01);
    applyStimulus('0, '0, 4'b0001, slotWid(0, 0), 1'b0, '0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w0_was_one", 32'(bus.pending), 'h00);

    // fence warp 3 with two instructions in flight
    applyStimulus(4'b1000, slotWid(3, 3), '0, '0, 1'b0, '0);
    tick(); tick();
    applyStimulus('0, '0, '0, '0, 1'b1, 3'd3);
    checkOutput("f3_ready_before", 32'(bus.fence_ready), 'h1);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("f3_ready_wait", 32'(bus.fence_ready), 'h0);
    checkOutput("f3_done_wait", 32'(bus.fence_done), 'h0);
    checkOutput("f3_pending", 32'(bus.pending), 'h08);
    applyStimulus('0, '0, 4'b1000, slotWid(3, 3), 1'b0, '0);
    tick(); tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("f3_done_at_drain", 32'(bus.fence_done), 'h0);
    checkOutput("f3_drained", 32'(bus.pending), 'h00);
    tick();
    checkOutput("f3_done_pulse", 32'(bus.fence_done), 'h1);
    checkOutput("f3_ready_in_done", 32'(bus.fence_ready), 'h0);
    tick();
    checkOutput("f3_done_end", 32'(bus.fence_done), 'h0);
    checkOutput("f3_ready_back", 32'(bus.fence_ready), 'h1);

    // fence on already-drained warp 6
    applyStimulus('0, '0, '0, '0, 1'b1, 3'd6);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("f6_done_c1", 32'(bus.fence_done), 'h0);
    tick();
    checkOutput("f6_done_c2", 32'(bus.fence_done), 'h1);
    tick();
    checkOutput("f6_done_c3", 32'(bus.fence_done), 'h0);
    checkOutput("f6_ready", 32'(bus.fence_ready), 'h1);

    // commit to empty warp 5 must not wrap
    applyStimulus('0, '0, 4'b0010, slotWid(1, 5), 1'b0, '0);
    tick();
    applyStimulus('0, slotWid(1, 5), '0, '0, 1'b0, '0);
    checkOutput("w5_underflow_pending", 32'(bus.pending), 'h00);
    checkOutput("w5_underflow_ready", 32'(bus.issue_ready), 'hF);
    applyStimulus(4'b0010, slotWid(1, 5), '0, '0, 1'b0, '0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w5_one", 32'(bus.pending), 'h20);
    applyStimulus('0, '0, 4'b0010, slotWid(1, 5), 1'b0, '0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("w5_zero", 32'(bus.pending), 'h00);

    // reset while a fence waits on warp 4
    applyStimulus(4'b0001, slotWid(0, 4), '0, '0, 1'b0, '0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b1, 3'd4);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    tick();
    checkOutput("f4_waiting", 32'(bus.fence_ready), 'h0);
    reset = 1'b1;
    applyStimulus(4'b0001, slotWid(0, 4), 4'b0010, slotWid(1, 5), 1'b0, '0);
    tick();
    reset = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0, '0);
    checkOutput("rst_mid_done", 32'(bus.fence_done), 'h0);
    checkOutput("rst_mid_ready", 32'(bus.fence_ready), 'h1);
    checkOutput("rst_mid_idle", 32'(bus.idle), 'h1);
    checkOutput("rst_mid_pending", 32'(bus.pending), 'h00);
    tick();
    checkOutput("rst_mid_no_done", 32'(bus.fence_done), 'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
